// File: rtl/clk_sel_pkg.sv
// ----------------------------------------------------------------------------
// clk_sel_pkg
//   Shared types and default constants for the clock-select controller.
//   - clk_sel_state_t    : controller FSM states (IDLE, SETTLE, DWELL)
//   - CLK_SEL_SETTLE_DEF : default settle window, in controller clocks
//   - CLK_SEL_DWELL_DEF  : default dwell window, in controller clocks
//   - CLK_SEL_CNT_W_DEF  : default width of the window down-counter
// ----------------------------------------------------------------------------
package clk_sel_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DWELL  = 2'd2
    } clk_sel_state_t;

    localparam int CLK_SEL_SETTLE_DEF = 8;
    localparam int CLK_SEL_DWELL_DEF  = 16;
    localparam int CLK_SEL_CNT_W_DEF  = 8;

endpackage

// File: rtl/clk_sel_cnt.sv
// ----------------------------------------------------------------------------
// clk_sel_cnt
//   Loadable down-counter that times the settle and dwell windows.
//   Ports:
//     clk, rst_n  : controller clock, asynchronous active-low reset
//     load        : load load_val on the next edge (wins over en)
//     load_val    : value to load
//     en          : decrement on the next edge; holds at zero (no underflow)
//     zero        : count is zero (decoded from the register)
// ----------------------------------------------------------------------------
module clk_sel_cnt
    import clk_sel_pkg::*;
#(
    parameter int CNT_W = CLK_SEL_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/clk_sel_ctrl.sv
// ----------------------------------------------------------------------------
// clk_sel_ctrl
//   Drives the select input of the glitch-free clock mux. Accepts switch
//   requests, registers the select, then blocks further requests for a
//   settle window (mux hand-over) followed by a minimum dwell window.
//
//   Optional feature: define CLK_SEL_FALLBACK_EN to force select back to
//   source 0 when src_fail reports source 1 as failed. Without it src_fail
//   is ignored and rej is tied low. The port list is the same either way.
//
//   Handshake: a request is consumed on any rising edge where
//   req_valid && req_ready; req_ready is high only in IDLE and is decoded
//   from registered state. The requester keeps req_valid/req_sel stable
//   until consumed.
//
//   Ports:
//     clk, rst_n : controller clock, asynchronous active-low reset
//     req_valid  : switch request valid
//     req_sel    : requested source (0 = clk1, 1 = clk2)
//     req_ready  : controller can take a request (state == IDLE)
//     select     : registered mux select
//     busy       : registered, high in SETTLE and DWELL
//     sw_done    : one-cycle pulse when a switch or no-op completes
//     src_fail   : source 1 failed (fallback build only)
//     rej        : one-cycle pulse when a request is dropped (fallback build)
//
//   The current FSM state is the internal signal 'state' for checkers.
// ----------------------------------------------------------------------------
module clk_sel_ctrl
    import clk_sel_pkg::*;
#(
    parameter int SETTLE_CYCLES = CLK_SEL_SETTLE_DEF,
    parameter int DWELL_CYCLES  = CLK_SEL_DWELL_DEF,
    parameter int CNT_W         = CLK_SEL_CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    input  logic req_sel,
    output logic req_ready,
    output logic select,
    output logic busy,
    output logic sw_done,
    input  logic src_fail,
    output logic rej
);

    // Window lengths must be at least 1 and their load value (N-1) must
    // fit in the counter.
    generate
        if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > (1 << CNT_W))) begin : g_bad_settle
            $error("clk_sel_ctrl: SETTLE_CYCLES out of range for CNT_W");
        end
        if ((DWELL_CYCLES < 1) || (DWELL_CYCLES > (1 << CNT_W))) begin : g_bad_dwell
            $error("clk_sel_ctrl: DWELL_CYCLES out of range for CNT_W");
        end
    endgenerate

    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LD  = CNT_W'(DWELL_CYCLES - 1);

    clk_sel_state_t   state;
    logic             rej_q;
    logic             accept;
    logic             fb_fire;   // forced fall-back to source 0 this edge
    logic             drop;      // accepted request must be discarded
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_en;
    logic             cnt_zero;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;

`ifdef CLK_SEL_FALLBACK_EN
    assign fb_fire = src_fail && select;
    assign drop    = src_fail && req_sel;
    assign rej     = rej_q;
`else
    logic unused_src_fail;
    assign unused_src_fail = src_fail;
    assign fb_fire = 1'b0;
    assign drop    = 1'b0;
    assign rej     = 1'b0;
`endif

    // Counter control mirrors the transitions made by the FSM below.
    always_comb begin
        cnt_load     = 1'b0;
        cnt_load_val = SETTLE_LD;
        cnt_en       = 1'b0;
        if (fb_fire) begin
            cnt_load = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && !drop && (req_sel != select)) begin
                        cnt_load = 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt_zero) begin
                        cnt_load     = 1'b1;
                        cnt_load_val = DWELL_LD;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                DWELL: begin
                    cnt_en = !cnt_zero;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            select  <= 1'b0;
            busy    <= 1'b0;
            sw_done <= 1'b0;
            rej_q   <= 1'b0;
        end else begin
            sw_done <= 1'b0;
            rej_q   <= 1'b0;
            if (fb_fire) begin
                // Pre-empts any state. A request taken on the same edge
                // asking for source 1 is dropped; one asking for source 0
                // is satisfied by the fall-back itself.
                select <= 1'b0;
                state  <= SETTLE;
                busy   <= 1'b1;
                if (accept && req_sel) begin
                    rej_q <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            if (drop) begin
                                rej_q <= 1'b1;
                            end else if (req_sel == select) begin
                                sw_done <= 1'b1;
                            end else begin
                                select <= req_sel;
                                state  <= SETTLE;
                                busy   <= 1'b1;
                            end
                        end
                    end
                    SETTLE: begin
                        if (cnt_zero) begin
                            sw_done <= 1'b1;
                            state   <= DWELL;
                        end
                    end
                    DWELL: begin
                        if (cnt_zero) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    clk_sel_cnt #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// ----------------------------------------------------------------------------
// tb_clk_sel_ctrl
//   Directed self-checking bench for clk_sel_ctrl with default parameters
//   (settle 8, dwell 16). Inputs change and outputs are sampled 1 ns after
//   the rising edge. Fall-back scenarios are built when CLK_SEL_FALLBACK_EN
//   is defined; otherwise src_fail is shown to be ignored.
// ----------------------------------------------------------------------------
module tb_clk_sel_ctrl;

    localparam int S = 8;
    localparam int D = 16;

    logic clk;
    logic rst_n;
    logic req_valid;
    logic req_sel;
    logic req_ready;
    logic select;
    logic busy;
    logic sw_done;
    logic src_fail;
    logic rej;

    int n_checks;
    int n_fail;

    clk_sel_ctrl #(
        .SETTLE_CYCLES(S),
        .DWELL_CYCLES (D),
        .CNT_W        (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_sel  (req_sel),
        .req_ready(req_ready),
        .select   (select),
        .busy     (busy),
        .sw_done  (sw_done),
        .src_fail (src_fail),
        .rej      (rej)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_sel   = 1'b0;
        src_fail  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Bounded wait for IDLE; an expired bound counts as a failure.
    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!req_ready && n < 100) begin
            tick();
            n++;
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: timeout waiting for req_ready, got %b want 1", name, req_ready);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({select, busy, sw_done, req_ready, rej} !== 5'b00010) begin
            n_fail++;
            $display("FAIL reset_state: got sel/busy/done/rdy/rej=%b want 00010",
                     {select, busy, sw_done, req_ready, rej});
        end
    endtask

    // select = 0, request 0: sw_done next cycle, never busy.
    task automatic test_noop();
        req_valid = 1'b1;
        req_sel   = 1'b0;
        tick();
        req_valid = 1'b0;
        n_checks++;
        if ({select, busy, sw_done, req_ready} !== 4'b0011) begin
            n_fail++;
            $display("FAIL noop_done: got sel/busy/done/rdy=%b want 0011",
                     {select, busy, sw_done, req_ready});
        end
        tick();
        n_checks++;
        if ({busy, sw_done} !== 2'b00) begin
            n_fail++;
            $display("FAIL noop_pulse: got busy/done=%b want 00", {busy, sw_done});
        end
    endtask

    // Two consecutive no-ops: both accepted, sw_done high two cycles.
    task automatic test_back_to_back();
        req_valid = 1'b1;
        req_sel   = 1'b0;
        tick();
        n_checks++;
        if ({sw_done, busy, req_ready} !== 3'b101) begin
            n_fail++;
            $display("FAIL b2b_first: got done/busy/rdy=%b want 101", {sw_done, busy, req_ready});
        end
        tick();
        req_valid = 1'b0;
        n_checks++;
        if ({sw_done, busy, req_ready} !== 3'b101) begin
            n_fail++;
            $display("FAIL b2b_second: got done/busy/rdy=%b want 101", {sw_done, busy, req_ready});
        end
        tick();
        n_checks++;
        if (sw_done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: got sw_done=%b want 0", sw_done);
        end
    endtask

    // 0 -> 1 switch, cycle-by-cycle window timing.
    task automatic test_switch();
        req_valid = 1'b1;
        req_sel   = 1'b1;
        tick();                       // E0
        req_valid = 1'b0;
        n_checks++;
        if ({select, busy, sw_done, req_ready} !== 4'b1100) begin
            n_fail++;
            $display("FAIL switch_e0: got sel/busy/done/rdy=%b want 1100",
                     {select, busy, sw_done, req_ready});
        end
        for (int k = 1; k <= S + D; k++) begin
            tick();                   // edge E0+k
            n_checks++;
            if (sw_done !== (k == S) || req_ready !== (k >= S + D) ||
                busy !== (k < S + D) || select !== 1'b1) begin
                n_fail++;
                $display("FAIL switch_window k=%0d: got done/rdy/busy/sel=%b%b%b%b want %b%b%b1",
                         k, sw_done, req_ready, busy, select,
                         (k == S), (k >= S + D), (k < S + D));
            end
        end
    endtask

    // select = 1, request 1: no-op.
    task automatic test_noop_sel1();
        req_valid = 1'b1;
        req_sel   = 1'b1;
        tick();
        req_valid = 1'b0;
        n_checks++;
        if ({select, busy, sw_done, req_ready} !== 4'b1011) begin
            n_fail++;
            $display("FAIL noop1_done: got sel/busy/done/rdy=%b want 1011",
                     {select, busy, sw_done, req_ready});
        end
    endtask

    // 1 -> 0 switch, then a request held through SETTLE/DWELL until taken.
    task automatic test_held_request();
        req_valid = 1'b1;
        req_sel   = 1'b0;
        tick();                       // E0
        req_sel   = 1'b1;             // new request held from here on
        n_checks++;
        if ({select, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL held_e0: got sel/busy=%b want 01", {select, busy});
        end
        for (int k = 1; k <= S + D; k++) begin
            tick();
            n_checks++;
            if (select !== 1'b0 || sw_done !== (k == S)) begin
                n_fail++;
                $display("FAIL held_wait k=%0d: got sel/done=%b%b want 0%b",
                         k, select, sw_done, (k == S));
            end
        end
        tick();                       // E1 = E0+S+D+1, accepted here
        req_valid = 1'b0;
        n_checks++;
        if ({select, busy, req_ready} !== 3'b110) begin
            n_fail++;
            $display("FAIL held_accept: got sel/busy/rdy=%b want 110", {select, busy, req_ready});
        end
        for (int k = 1; k <= S; k++) begin
            tick();
            n_checks++;
            if (sw_done !== (k == S)) begin
                n_fail++;
                $display("FAIL held_done k=%0d: got sw_done=%b want %b", k, sw_done, (k == S));
            end
        end
        wait_idle("held_idle");
    endtask

    // Asynchronous reset in the middle of SETTLE.
    task automatic test_reset_mid_settle();
        req_valid = 1'b1;
        req_sel   = 1'b0;
        tick();
        req_valid = 1'b0;
        wait_idle("rstmid_prep");
        req_valid = 1'b1;
        req_sel   = 1'b1;
        tick();                       // E0, select -> 1
        req_valid = 1'b0;
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({select, busy, sw_done, req_ready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL rstmid_async: got sel/busy/done/rdy=%b want 0001",
                     {select, busy, sw_done, req_ready});
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < S + 2; k++) begin
            tick();
            n_checks++;
            if ({select, busy, sw_done, req_ready} !== 4'b0001) begin
                n_fail++;
                $display("FAIL rstmid_after k=%0d: got sel/busy/done/rdy=%b want 0001",
                         k, {select, busy, sw_done, req_ready});
            end
        end
    endtask

`ifdef CLK_SEL_FALLBACK_EN
    task automatic test_fallback();
        req_valid = 1'b1;
        req_sel   = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < S + 2; k++) tick();   // now in DWELL
        src_fail = 1'b1;
        tick();
        src_fail = 1'b0;
        n_checks++;
        if ({select, busy, sw_done, req_ready} !== 4'b0100) begin
            n_fail++;
            $display("FAIL fb_force: got sel/busy/done/rdy=%b want 0100",
                     {select, busy, sw_done, req_ready});
        end
        for (int k = 1; k <= S; k++) begin
            tick();
            n_checks++;
            if (sw_done !== (k == S)) begin
                n_fail++;
                $display("FAIL fb_done k=%0d: got sw_done=%b want %b", k, sw_done, (k == S));
            end
        end
        wait_idle("fb_idle");
    endtask

    task automatic test_src_fail_reject();
        src_fail  = 1'b1;
        req_valid = 1'b1;
        req_sel   = 1'b1;
        tick();
        req_valid = 1'b0;
        n_checks++;
        if ({rej, select, sw_done, req_ready} !== 4'b1001) begin
            n_fail++;
            $display("FAIL rej_pulse: got rej/sel/done/rdy=%b want 1001",
                     {rej, select, sw_done, req_ready});
        end
        tick();
        src_fail = 1'b0;
        n_checks++;
        if ({rej, select, sw_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL rej_end: got rej/sel/done=%b want 000", {rej, select, sw_done});
        end
    endtask
`else
    // src_fail has no effect: the request switches normally, rej stays 0.
    task automatic test_src_fail_ignored();
        src_fail  = 1'b1;
        req_valid = 1'b1;
        req_sel   = 1'b1;
        tick();
        req_valid = 1'b0;
        n_checks++;
        if ({rej, select, busy} !== 3'b011) begin
            n_fail++;
            $display("FAIL nofb_switch: got rej/sel/busy=%b want 011", {rej, select, busy});
        end
        for (int k = 1; k <= S; k++) tick();
        n_checks++;
        if ({sw_done, select, rej} !== 3'b110) begin
            n_fail++;
            $display("FAIL nofb_done: got done/sel/rej=%b want 110", {sw_done, select, rej});
        end
        src_fail = 1'b0;
        wait_idle("nofb_idle");
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_noop();
        test_back_to_back();
        test_switch();
        test_noop_sel1();
        test_held_request();
        test_reset_mid_settle();
`ifdef CLK_SEL_FALLBACK_EN
        test_fallback();
        test_src_fail_reject();
`else
        test_src_fail_ignored();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_sel_ctrl.md
# clk_sel_ctrl

Single-clock controller that drives the `select` input of the glitch-free clock mux. It accepts clock-source switch requests over a valid/ready handshake and registers the mux select. After each change it holds off further requests for a settle window, while the mux completes its hand-over, and then for a minimum dwell window. An optional fallback forces the mux back to source 0 (`clk1`) when source 1 is reported failed.

## Interface
- `SETTLE_CYCLES`, 8: cycles after a select change before `sw_done` pulses; range 1..2^CNT_W.
- `DWELL_CYCLES`, 16: minimum cycles after `sw_done` before the next request is accepted; range 1..2^CNT_W.
- `CNT_W`, 8: width of the internal down-counter.
- `clk` input 1: controller clock, free-running and independent of both mux sources.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: switch request valid.
- `req_sel` input 1: requested source; 0 = `clk1`, 1 = `clk2`.
- `req_ready` output 1: request accepted on a cycle where `req_valid && req_ready`.
- `select` output 1: registered mux select; connects directly to the mux.
- `busy` output 1: high in the SETTLE and DWELL states.
- `sw_done` output 1: one-cycle pulse when a switch (or no-op) completes.
- `src_fail` input 1: synchronous to `clk`; source 1 failed (used only with the macro).
- `rej` output 1: one-cycle pulse when a request is dropped (only with the macro).

## Operation
- Reset state (async, `rst_n` = 0): state IDLE, `select` = 0, `req_ready` = 1, `busy` = 0, `sw_done` = 0, `rej` = 0, counter = 0.
- FSM states: IDLE, SETTLE, DWELL. `req_ready` = (state == IDLE). `busy` = (state != IDLE).
- IDLE, request accepted with `req_sel` == `select`: no-op.
  - `sw_done` pulses on the next cycle; state stays IDLE; `req_ready` stays 1.
- IDLE, request accepted with `req_sel` != `select`:
  - `select` <= `req_sel`; counter <= SETTLE_CYCLES-1; state -> SETTLE.
- SETTLE: counter decrements each cycle. At counter == 0:
  - `sw_done` <= 1 (one cycle); counter <= DWELL_CYCLES-1; state -> DWELL.
- DWELL: counter decrements each cycle. At counter == 0, state -> IDLE.
- `req_valid` while `req_ready` = 0 is not consumed. The requester holds `req_valid`/`req_sel` stable until accepted.
- Reset mid-SETTLE/DWELL: all outputs return to their reset values immediately (asynchronous); no `sw_done` is issued.
- The counter never underflows. `CNT_W` too small for either parameter is an elaboration error.

## Timing
- The acceptance edge is E0. `select` changes at E0 and is visible in the cycle after E0.
- `sw_done` is high in the cycle following edge E0+SETTLE_CYCLES.
- `req_ready` returns to 1 after edge E0+SETTLE_CYCLES+DWELL_CYCLES. Minimum request-to-request spacing is SETTLE_CYCLES+DWELL_CYCLES+1 cycles.
- No-op latency: `sw_done` is high in the cycle after E0.
- All outputs are registered; there is no combinational path from inputs to outputs except `req_ready`, which is decoded from registered state only.

## Configuration
- `CLK_SEL_FALLBACK_EN` defined:
  - `src_fail` = 1 with `select` = 1, in any state: the next edge sets `select` <= 0, counter <= SETTLE_CYCLES-1, state -> SETTLE. This pre-empts both SETTLE and DWELL.
  - While `src_fail` = 1, an accepted request with `req_sel` = 1 is dropped: `rej` pulses for one cycle and there is no `sw_done`.
  - An accepted request with `req_sel` = 0 is handled normally.
- `CLK_SEL_FALLBACK_EN` undefined: `src_fail` is ignored and `rej` is tied to 0.
- The port list is identical in both builds.

## Structure
- Package `clk_sel_pkg` holds:
  - the state enum `clk_sel_state_t` (IDLE, SETTLE, DWELL);
  - default constants `CLK_SEL_SETTLE_DEF` = 8, `CLK_SEL_DWELL_DEF` = 16, `CLK_SEL_CNT_W_DEF` = 8.
- Sub-module `clk_sel_cnt`: loadable `CNT_W`-bit down-counter with load, enable and `zero` flag. Instantiated once.

## Test plan
- Reset, then request `req_sel` = 1 at E0 → `select` = 1 after E0; `sw_done` high in the cycle after E0+8; `req_ready` low until edge E0+24.
- `req_valid` held high during DWELL with `req_sel` = 0 → not accepted until `req_ready` = 1; then `select` = 0 and `sw_done` follows 8 cycles later.
- Request `req_sel` = 0 while `select` = 0 → `sw_done` in the next cycle; `busy` stays 0.
- Assert `rst_n` = 0 midway through SETTLE → `select`, `busy` and `sw_done` are 0 immediately; after release, `req_ready` = 1.
- With `CLK_SEL_FALLBACK_EN`: `select` = 1 in DWELL, pulse `src_fail` → `select` = 0 next cycle; `sw_done` 8 cycles later.
- With `CLK_SEL_FALLBACK_EN`: `src_fail` held high, request `req_sel` = 1 → `rej` one-cycle pulse; `select` stays 0.
